debug_uart_tx: RTL

- Response framer and serializer for the debug unit's UART link; the transmit end of the host protocol whose receive side decodes OP_PING/OP_PAUSE/OP_RESUME/OP_NEXT/OP_PROGRAM.
- Sends OP_OK (8'h02) as a single byte when a ping is acknowledged.
- Sends OP_SIGNAL (8'h01) followed by the 32-bit PC and a fixed signal-snapshot payload.
- Sits between the debug controller and the top-level uart_tx pin; 8N1, LSB first.

---
 rtl/debug_pkg.sv | 37 +++
 rtl/uart_byte_tx.sv | 118 +++++++++++
 rtl/debug_uart_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit's UART host protocol: opcodes used by
// both the receive decoder and the response transmitter, default link timing,
// and the state encodings of the transmit path.
package debug_pkg;

  // Response opcodes sent to the host
  localparam logic [7:0] OP_SIGNAL  = 8'h01;
  localparam logic [7:0] OP_OK      = 8'h02;
  // Host command opcodes decoded by the receiver
  localparam logic [7:0] OP_PING    = 8'h03;
  localparam logic [7:0] OP_PAUSE   = 8'h04;
  localparam logic [7:0] OP_RESUME  = 8'h05;
  localparam logic [7:0] OP_NEXT    = 8'h06;
  localparam logic [7:0] OP_PROGRAM = 8'h07;

  // 100 MHz system clock, 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int SIG_BYTES_DEFAULT    = 4;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_XMIT = 1'b1
  } pkt_state_e;

  // Bytes in an OP_SIGNAL packet: opcode, 4 PC bytes, then the snapshot
  function automatic int signal_pkt_len(input int sig_bytes);
    return 5 + sig_bytes;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer, LSB first. `ready` is high when idle and also during
// the final cycle of the stop bit, so a new byte accepted in that cycle
// follows with no idle gap on the line.
module uart_byte_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};

  ser_state_e    state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic          tx_r, tx_s;
  logic          bit_end_s;

  assign bit_end_s = (baud_r == BAUD_LAST);
  assign ready     = (state_r == SER_IDLE) || ((state_r == SER_STOP) && bit_end_s);
  assign tx        = tx_r;

  // Next-state logic: bit timing, shift register and the registered line value
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    case (state_r)
      SER_IDLE: begin
        baud_s = BAUD_ZERO;
        if (start) begin
          state_s = SER_START;
          shift_s = data;
          bit_s   = 3'd0;
          tx_s    = 1'b0;
        end else begin
          tx_s    = 1'b1;
        end
      end
      SER_START: begin
        if (bit_end_s) begin
          baud_s  = BAUD_ZERO;
          state_s = SER_DATA;
          tx_s    = shift_r[0];
        end else begin
          baud_s  = baud_r + BAUD_ONE;
        end
      end
      SER_DATA: begin
        if (bit_end_s) begin
          baud_s = BAUD_ZERO;
          if (bit_r == 3'd7) begin
            state_s = SER_STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      SER_STOP: begin
        if (bit_end_s) begin
          baud_s = BAUD_ZERO;
          if (start) begin
            state_s = SER_START;
            shift_s = data;
            bit_s   = 3'd0;
            tx_s    = 1'b0;
          end else begin
            state_s = SER_IDLE;
            tx_s    = 1'b1;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_s = SER_IDLE;
        baud_s  = BAUD_ZERO;
        bit_s   = 3'd0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // Serializer state register; reset forces the line high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SER_IDLE;
      baud_r  <= BAUD_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug-unit response transmitter: queues OP_OK and OP_SIGNAL requests,
// frames them into packets and feeds the byte serializer back to back.
module debug_uart_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SIG_BYTES    = SIG_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_ok,
  input  logic                   req_signal,
  input  logic [31:0]            pc,
  input  logic [SIG_BYTES*8-1:0] signals,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   uart_tx
);

  localparam int PAY_W   = 32 + SIG_BYTES * 8;
  localparam int SIG_LEN = signal_pkt_len(SIG_BYTES);
  localparam int CW      = $clog2(SIG_LEN + 1);
  localparam logic [CW-1:0] LEFT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] LEFT_ONE  = CW'(1);
  localparam logic [CW-1:0] LEFT_SIG  = CW'(SIG_LEN - 1);

  pkt_state_e       state_r, state_s;
  logic             pend_ok_r, pend_ok_s;
  logic             pend_sig_r, pend_sig_s;
  logic [PAY_W-1:0] shadow_r, shadow_s;
  logic [PAY_W-1:0] payload_r, payload_s;
  logic [CW-1:0]    left_r, left_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             byte_start_s;
  logic [7:0]       byte_data_s;
  logic             byte_ready_s;

  assign busy     = busy_r;
  assign pkt_done = done_r;

  // Packet sequencing, pending-request bookkeeping and snapshot capture
  always_comb begin
    state_s      = state_r;
    pend_ok_s    = pend_ok_r;
    pend_sig_s   = pend_sig_r;
    shadow_s     = shadow_r;
    payload_s    = payload_r;
    left_s       = left_r;
    done_s       = 1'b0;
    byte_start_s = 1'b0;
    byte_data_s  = payload_r[7:0];
    case (state_r)
      PKT_IDLE: begin
        if (pend_ok_r) begin
          byte_start_s = 1'b1;
          byte_data_s  = OP_OK;
          left_s       = LEFT_ZERO;
          pend_ok_s    = 1'b0;
          state_s      = PKT_XMIT;
        end else if (pend_sig_r) begin
          // Freeze the snapshot for the whole packet
          byte_start_s = 1'b1;
          byte_data_s  = OP_SIGNAL;
          payload_s    = shadow_r;
          left_s       = LEFT_SIG;
          pend_sig_s   = 1'b0;
          state_s      = PKT_XMIT;
        end else begin
          state_s      = PKT_IDLE;
        end
      end
      PKT_XMIT: begin
        if (byte_ready_s) begin
          if (left_r != LEFT_ZERO) begin
            byte_start_s = 1'b1;
            byte_data_s  = payload_r[7:0];
            payload_s    = payload_r >> 8;
            left_s       = left_r - LEFT_ONE;
          end else begin
            done_s       = 1'b1;
            state_s      = PKT_IDLE;
          end
        end else begin
          state_s = PKT_XMIT;
        end
      end
      default: begin
        state_s = PKT_IDLE;
      end
    endcase

    // New requests win over the clear that happens when a packet starts
    if (req_ok) begin
      pend_ok_s = 1'b1;
    end else begin
      pend_ok_s = pend_ok_s;
    end
    if (req_signal) begin
      pend_sig_s = 1'b1;
      shadow_s   = {signals, pc};
    end else begin
      pend_sig_s = pend_sig_s;
    end

    busy_s = (state_s != PKT_IDLE) || pend_ok_s || pend_sig_s;
  end

  // Packet state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= PKT_IDLE;
      pend_ok_r  <= 1'b0;
      pend_sig_r <= 1'b0;
      shadow_r   <= {PAY_W{1'b0}};
      payload_r  <= {PAY_W{1'b0}};
      left_r     <= LEFT_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pend_ok_r  <= pend_ok_s;
      pend_sig_r <= pend_sig_s;
      shadow_r   <= shadow_s;
      payload_r  <= payload_s;
      left_r     <= left_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(byte_start_s),
    .data (byte_data_s),
    .ready(byte_ready_s),
    .tx   (uart_tx)
  );

endmodule
